// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl
// -----------------------------------------------------------------------------
// Sequencer for D-flip-flop shift-register chains. A parallel word is taken
// over a LOAD/RDY handshake and serialised LSB-first on SO, with SEN marking
// every cycle whose SO bit the downstream chain must clock in. BITCNT reports
// how many bits have gone out and DONE pulses once after the last bit.
//
// Optional feature (compile-time macro): SHIFT_CTRL_PARITY_EN
//   Defined   -> one extra SEN cycle after the data bits that carries the
//                even parity (XOR reduction) of the captured word.
//   Undefined -> exactly WIDTH bits per transfer.
//
// Ports
//   C       in   clock, rising edge
//   R       in   asynchronous active-high reset
//   DIN     in   [WIDTH] parallel word, sampled only on the accepting edge
//   LOAD    in   word valid (accepted when RDY=1)
//   RDY     out  controller can accept a word (IDLE only)
//   ABORT   in   cancel the transfer in progress (SHIFT/PAR only)
//   SO      out  serial data to the chain's D input
//   SEN     out  shift enable, SO is valid this cycle
//   BUSY    out  transfer in progress
//   DONE    out  one-cycle completion pulse
//   BITCNT  out  [CNT_W] bits already shifted in this transfer
//
// All outputs decode registered state only; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module shift_reg_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    output logic             RDY,
    input  logic             ABORT,
    output logic             SO,
    output logic             SEN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] BITCNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef SHIFT_CTRL_PARITY_EN
        PAR   = 2'd2,
`endif
        FIN   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   buf_reg,   buf_next;
    logic [CNT_W-1:0]   cnt_reg,   cnt_next;
`ifdef SHIFT_CTRL_PARITY_EN
    logic               par_reg,   par_next;
`endif

    // State register
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_reg <= IDLE;
            buf_reg   <= '0;
            cnt_reg   <= '0;
`ifdef SHIFT_CTRL_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
            cnt_reg   <= cnt_next;
`ifdef SHIFT_CTRL_PARITY_EN
            par_reg   <= par_next;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        buf_next   = buf_reg;
        cnt_next   = cnt_reg;
`ifdef SHIFT_CTRL_PARITY_EN
        par_next   = par_reg;
`endif
        case (state_reg)
            IDLE: begin
                // LOAD wins over a simultaneous ABORT here; ABORT has no
                // meaning while idle.
                if (LOAD) begin
                    buf_next   = DIN;
                    cnt_next   = '0;
`ifdef SHIFT_CTRL_PARITY_EN
                    // Parity is taken from the word as captured, so later
                    // DIN changes and the draining buffer cannot disturb it.
                    par_next   = ^DIN;
`endif
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // ABORT outranks the end-of-word transition.
                if (ABORT) begin
                    buf_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    buf_next = buf_reg >> 1;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT) begin
`ifdef SHIFT_CTRL_PARITY_EN
                        state_next = PAR;
`else
                        state_next = FIN;
`endif
                    end
                end
            end
`ifdef SHIFT_CTRL_PARITY_EN
            PAR: begin
                if (ABORT) begin
                    buf_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    // BITCNT stays at WIDTH through PAR and FIN.
                    state_next = FIN;
                end
            end
`endif
            FIN: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                buf_next   = '0;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        RDY  = 1'b0;
        BUSY = 1'b0;
        SEN  = 1'b0;
        SO   = 1'b0;
        DONE = 1'b0;
        case (state_reg)
            IDLE: begin
                RDY = 1'b1;
            end
            SHIFT: begin
                BUSY = 1'b1;
                SEN  = 1'b1;
                SO   = buf_reg[0];
            end
`ifdef SHIFT_CTRL_PARITY_EN
            PAR: begin
                BUSY = 1'b1;
                SEN  = 1'b1;
                SO   = par_reg;
            end
`endif
            FIN: begin
                DONE = 1'b1;
            end
            default: begin
                RDY = 1'b0;
            end
        endcase
    end

    assign BITCNT = cnt_reg;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl.
// The reference model turns every accepted word into the list of per-cycle
// output values the controller must show (data cycles, optional parity cycle,
// completion cycle); idle is the implicit value once that list is empty.
// A second instance with WIDTH=2 drives a small D-flip-flop chain.
module tb_shift_reg_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = $clog2(W + 1);
`ifdef SHIFT_CTRL_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     din;
    logic             load, abort;
    logic             rdy, so, sen, busy, done;
    logic [CNT_W-1:0] bitcnt;

    logic [1:0]       din2;
    logic             load2, abort2;
    logic             rdy2, so2, sen2, busy2, done2;
    logic [1:0]       bitcnt2;
    logic             q1, q2;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.WIDTH(W)) u_dut (
        .C(clk), .R(rst), .DIN(din), .LOAD(load), .RDY(rdy), .ABORT(abort),
        .SO(so), .SEN(sen), .BUSY(busy), .DONE(done), .BITCNT(bitcnt)
    );

    shift_reg_ctrl #(.WIDTH(2)) u_dut2 (
        .C(clk), .R(rst), .DIN(din2), .LOAD(load2), .RDY(rdy2), .ABORT(abort2),
        .SO(so2), .SEN(sen2), .BUSY(busy2), .DONE(done2), .BITCNT(bitcnt2)
    );

    // Two-stage D-flip-flop chain fed by the WIDTH=2 instance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= 1'b0;
            q2 <= 1'b0;
        end else if (sen2) begin
            q1 <= so2;
            q2 <= q1;
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic             rdy;
        logic             busy;
        logic             sen;
        logic             so;
        logic             done;
        logic [CNT_W-1:0] cnt;
    } rec_t;

    rec_t         exp_q[$];
    logic [W:0]   words[$];
    logic [W:0]   coll;
    int           ncoll;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic rec_t cur_exp();
        rec_t r;
        if (exp_q.size() != 0) begin
            r = exp_q[0];
        end else begin
            r     = '0;
            r.rdy = 1'b1;
        end
        return r;
    endfunction

    function automatic void push_word(input logic [W-1:0] w);
        rec_t r;
        for (int i = 0; i < W; i++) begin
            r      = '0;
            r.busy = 1'b1;
            r.sen  = 1'b1;
            r.so   = w[i];
            r.cnt  = CNT_W'(i);
            exp_q.push_back(r);
        end
        if (PB == 1) begin
            r      = '0;
            r.busy = 1'b1;
            r.sen  = 1'b1;
            r.so   = ^w;
            r.cnt  = CNT_W'(W);
            exp_q.push_back(r);
        end
        r      = '0;
        r.done = 1'b1;
        r.cnt  = CNT_W'(W);
        exp_q.push_back(r);
        words.push_back((PB == 1) ? {^w, w} : {1'b0, w});
        coll  = '0;
        ncoll = 0;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        words.delete();
        coll  = '0;
        ncoll = 0;
    endfunction

    task automatic check_outputs();
        rec_t e;
        e = cur_exp();
        check("rdy",    rdy,    e.rdy);
        check("busy",   busy,   e.busy);
        check("sen",    sen,    e.sen);
        check("so",     so,     e.so);
        check("done",   done,   e.done);
        check("bitcnt", bitcnt, e.cnt);
        if (e.sen && ncoll <= W) begin
            coll[ncoll] = so;
            ncoll++;
        end
        if (e.done && words.size() != 0) begin
            check("word", coll, words.pop_front());
            coll  = '0;
            ncoll = 0;
        end
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge
    task automatic cycle();
        rec_t cur;
        @(posedge clk);
        cur = cur_exp();
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (cur.rdy && load) begin
            push_word(din);
        end else if (cur.sen && abort) begin
            model_reset();
        end
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy"},    rdy,    1);
        check({tag, "_sen"},    sen,    0);
        check({tag, "_so"},     so,     0);
        check({tag, "_bitcnt"}, bitcnt, 0);
        check({tag, "_busy"},   busy,   0);
        check({tag, "_done"},   done,   0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] a5_seq;
        int         nsen;
        logic       last_bit;
        int         last_acc;

        rst = 1'b1; load = 1'b0; abort = 1'b0; din = '0;
        load2 = 1'b0; abort2 = 1'b0; din2 = '0;
        model_reset();
        #3;
        check_idle("rst0");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle();

        // A5: SO sequence 1,0,1,0,0,1,0,1 (LSB first)
        a5_seq = 8'b1010_0101;
        din = 8'hA5; load = 1'b1;
        cycle();
        load = 1'b0; din = W'($urandom);
        for (int i = 0; i < W; i++) begin
            check("a5_so", so, a5_seq[i]);
            cycle();
        end
        if (PB == 1) cycle();
        check("a5_done", done, 1);
        cycle();
        check("a5_rdy", rdy, 1);

        // 07: count SEN cycles and the final bit
        din = 8'h07; load = 1'b1;
        cycle();
        load = 1'b0;
        nsen = 0; last_bit = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (!sen) break;
            nsen++;
            last_bit = so;
            cycle();
        end
        check("p07_sen_cycles", nsen, W + PB);
        check("p07_last_bit", last_bit, (PB == 1) ? 1 : 0);
        check("p07_done", done, 1);
        repeat (2) cycle();

        // ABORT at BITCNT=3 during FF, then load 01
        din = 8'hFF; load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        check("ab_cnt", bitcnt, 3);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("ab_rdy", rdy, 1);
        check("ab_sen", sen, 0);
        check("ab_done", done, 0);
        repeat (W + 2) cycle();
        din = 8'h01; load = 1'b1;
        cycle();
        load = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("ld01_so", so, (i == 0) ? 1 : 0);
            cycle();
        end
        repeat (3) cycle();

        // LOAD held high, DIN changing every cycle
        last_acc = -1;
        load = 1'b1;
        for (int n = 0; n < 45; n++) begin
            din = W'($urandom);
            if (rdy) begin
                if (last_acc >= 0) check("cont_spacing", cyc - last_acc, W + 2 + PB);
                last_acc = cyc;
            end
            cycle();
        end
        load = 1'b0;
        repeat (W + 4) cycle();

        // Random LOAD / ABORT / DIN
        for (int n = 0; n < 400; n++) begin
            din   = W'($urandom);
            load  = ($urandom_range(0, 2) == 0);
            abort = ($urandom_range(0, 15) == 0);
            cycle();
        end
        load = 1'b0; abort = 1'b0;
        repeat (W + 4) cycle();

        // WIDTH=2 instance into a 2-bit chain, DIN=2'b10
        din2 = 2'b10; load2 = 1'b1;
        cycle();
        load2 = 1'b0; din2 = 2'b01;
        for (int i = 0; i < 10; i++) begin
            if (done2) break;
            cycle();
        end
        check("w2_done", done2, 1);
        check("w2_q1", q1, 1);
        check("w2_q2", q2, (PB == 1) ? 1 : 0);
        check("w2_bitcnt", bitcnt2, 2);
        check("w2_rdy", rdy2, 0);
        check("w2_busy", busy2, 0);
        cycle();
        check("w2_rdy_back", rdy2, 1);

        // Reset in the middle of a transfer, between clock edges
        din = W'($urandom); load = 1'b1;
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        #2 rst = 1'b1;
        #1 check_idle("rst_mid");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
